// File: rtl/sample_fetcher.sv
// Requests samples from a sine generator on each sample tick, buffers them in a FWFT FIFO and
// tracks note duration. Define SAMPLE_FETCHER_TIMEOUT_EN to bound the wait for sample_ready.
module sample_fetcher #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_play,
    input  logic        i_load_note,
    input  logic [19:0] i_step_size_in,
    input  logic [5:0]  i_duration,
    input  logic        i_beat,
    input  logic        i_sample_tick,
    output logic        o_generate_next,
    output logic [19:0] o_step_size,
    input  logic        i_sample_ready,
    input  logic [15:0] i_sample,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [15:0] o_out_sample,
    output logic        o_note_done,
    output logic        o_overrun,
    output logic        o_busy,
    output logic        o_timeout_err
);

    localparam int unsigned PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT == 0) begin : g_param_check
        $error("sample_fetcher: DEPTH must be a power of 2 >= 2 and TIMEOUT nonzero");
    end

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e        r_state;
    logic [19:0]   r_step_size;
    logic [5:0]    r_beats_left;
    logic          r_active;
    logic          r_note_done;
    logic          r_overrun;
    logic [15:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_slot_free;
    logic          w_tick_live;
    logic          w_start;
    logic          w_drop;
    logic          w_timeout;
    logic          w_push;
    logic          w_pop;
    logic [15:0]   w_push_data;

    // Only IDLE can start a request, so nothing is outstanding when this is consulted.
    assign w_slot_free = (r_count < CW'(DEPTH));
    assign w_tick_live = i_sample_tick & r_active & i_play;
    assign w_start     = w_tick_live & (r_state == StIdle) & w_slot_free;
    assign w_drop      = w_tick_live & ~w_start;
    assign w_push      = (r_state == StWait) & (i_sample_ready | w_timeout);
    assign w_push_data = i_sample_ready ? i_sample : 16'h0000;
    assign w_pop       = (r_count != '0) & i_out_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            unique case (r_state)
                StIdle:  if (w_start) r_state <= StReq;
                StReq:   r_state <= StWait;
                StWait:  if (w_push) r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_step_size  <= '0;
            r_beats_left <= '0;
            r_active     <= 1'b0;
            r_note_done  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_note_done <= 1'b0;
            if (i_load_note) begin
                r_step_size  <= i_step_size_in;
                r_beats_left <= i_duration;
                r_active     <= (i_duration != 6'd0);
                r_note_done  <= (i_duration == 6'd0);
                r_overrun    <= 1'b0;
            end else begin
                if (i_beat && r_active) begin
                    r_beats_left <= r_beats_left - 6'd1;
                    if (r_beats_left == 6'd1) begin
                        r_active    <= 1'b0;
                        r_note_done <= 1'b1;
                    end
                end
                if (w_drop) r_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_push_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop) r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

`ifdef SAMPLE_FETCHER_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] r_wait_cnt;
    logic          r_timeout_err;

    assign w_timeout = (r_state == StWait) & ~i_sample_ready & (r_wait_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_wait_cnt <= (r_state == StWait) ? r_wait_cnt + TW'(1) : '0;
            if (i_load_note) r_timeout_err <= 1'b0;
            else if (w_timeout) r_timeout_err <= 1'b1;
        end
    end

    assign o_timeout_err = r_timeout_err;
`else
    assign w_timeout     = 1'b0;
    assign o_timeout_err = 1'b0;
`endif

    assign o_generate_next = (r_state == StReq);
    assign o_busy          = (r_state != StIdle);
    assign o_step_size     = r_step_size;
    assign o_note_done     = r_note_done;
    assign o_overrun       = r_overrun;
    assign o_out_valid     = (r_count != '0);
    assign o_out_sample    = r_mem[r_rd_ptr];

endmodule

// File: tb/tb_sample_fetcher.sv
// Directed self-checking bench for sample_fetcher; generator responses are driven inline.
module tb_sample_fetcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        play;
    logic        load_note;
    logic [19:0] step_size_in;
    logic [5:0]  duration;
    logic        beat;
    logic        sample_tick;
    logic        generate_next;
    logic [19:0] step_size;
    logic        sample_ready;
    logic [15:0] sample;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sample;
    logic        note_done;
    logic        overrun;
    logic        busy;
    logic        timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    sample_fetcher #(.DEPTH(4), .TIMEOUT(15)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_play          (play),
        .i_load_note     (load_note),
        .i_step_size_in  (step_size_in),
        .i_duration      (duration),
        .i_beat          (beat),
        .i_sample_tick   (sample_tick),
        .o_generate_next (generate_next),
        .o_step_size     (step_size),
        .i_sample_ready  (sample_ready),
        .i_sample        (sample),
        .o_out_valid     (out_valid),
        .i_out_ready     (out_ready),
        .o_out_sample    (out_sample),
        .o_note_done     (note_done),
        .o_overrun       (overrun),
        .o_busy          (busy),
        .o_timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [19:0] st, input logic [5:0] dur);
        load_note    = 1'b1;
        step_size_in = st;
        duration     = dur;
        step();
        load_note = 1'b0;
    endtask

    task automatic tick_pulse();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
    endtask

    // Tick, then answer with data at T+3; returns in cycle T+4.
    task automatic fetch(input logic [15:0] data);
        tick_pulse();
        step();
        step();
        sample_ready = 1'b1;
        sample       = data;
        step();
        sample_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; play = 1'b0; load_note = 1'b0; step_size_in = '0; duration = '0;
        beat = 1'b0; sample_tick = 1'b0; sample_ready = 1'b0; sample = '0; out_ready = 1'b0;
        step();
        step();
        chk("rst_gen", 32'(generate_next), 0);
        chk("rst_step", 32'(step_size), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_sample", 32'(out_sample), 0);
        chk("rst_done", 32'(note_done), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        rst_n = 1'b1;
        step();

        // Basic latency
        play = 1'b1;
        do_load(20'h01000, 6'd3);
        chk("load_step", 32'(step_size), 32'h01000);
        chk("load_done", 32'(note_done), 0);
        tick_pulse();
        chk("lat_gen_t1", 32'(generate_next), 1);
        chk("lat_busy_t1", 32'(busy), 1);
        step();
        chk("lat_gen_t2", 32'(generate_next), 0);
        step();
        sample_ready = 1'b1;
        sample       = 16'h1234;
        chk("lat_valid_t3", 32'(out_valid), 0);
        step();
        sample_ready = 1'b0;
        chk("lat_valid_t4", 32'(out_valid), 1);
        chk("lat_sample_t4", 32'(out_sample), 32'h1234);
        chk("lat_busy_t4", 32'(busy), 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("drain1_valid", 32'(out_valid), 0);

        // Stray sample_ready in IDLE
        sample_ready = 1'b1;
        sample       = 16'hBEEF;
        step();
        sample_ready = 1'b0;
        chk("stray_valid", 32'(out_valid), 0);

        // Fill FIFO, fifth tick overruns
        for (int i = 0; i < 4; i++) begin
            fetch(16'hA001 + 16'(i));
            repeat (4) step();
        end
        chk("full_head", 32'(out_sample), 32'hA001);
        tick_pulse();
        chk("full_gen", 32'(generate_next), 0);
        chk("full_overrun", 32'(overrun), 1);
        chk("full_busy", 32'(busy), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 32'(out_valid), 1);
            chk("drain_order", 32'(out_sample), 32'hA001 + 32'(i));
            step();
        end
        out_ready = 1'b0;
        chk("drain_empty", 32'(out_valid), 0);

        // Tick while WAIT is dropped
        do_load(20'h00800, 6'd3);
        chk("reload_overrun", 32'(overrun), 0);
        tick_pulse();
        step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        chk("wait_tick_overrun", 32'(overrun), 1);
        chk("wait_tick_busy", 32'(busy), 1);
        sample_ready = 1'b1;
        sample       = 16'h5555;
        step();
        sample_ready = 1'b0;
        chk("wait_tick_sample", 32'(out_sample), 32'h5555);
        do_load(20'h00800, 6'd3);
        chk("load_clr_overrun", 32'(overrun), 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Simultaneous push and pop with count 2
        fetch(16'hB001);
        fetch(16'hB002);
        tick_pulse();
        step();
        step();
        sample_ready = 1'b1;
        sample       = 16'hB003;
        out_ready    = 1'b1;
        step();
        sample_ready = 1'b0;
        chk("pp_head1", 32'(out_sample), 32'hB002);
        step();
        chk("pp_head2", 32'(out_sample), 32'hB003);
        chk("pp_valid2", 32'(out_valid), 1);
        step();
        chk("pp_empty", 32'(out_valid), 0);
        out_ready = 1'b0;

        // Note expiry
        do_load(20'h00400, 6'd2);
        beat = 1'b1;
        step();
        beat = 1'b0;
        chk("beat1_done", 32'(note_done), 0);
        beat = 1'b1;
        step();
        beat = 1'b0;
        chk("beat2_done", 32'(note_done), 1);
        step();
        chk("done_pulse_end", 32'(note_done), 0);
        tick_pulse();
        chk("expired_gen", 32'(generate_next), 0);
        chk("expired_overrun", 32'(overrun), 0);
        chk("expired_busy", 32'(busy), 0);
        do_load(20'h00200, 6'd0);
        chk("dur0_done", 32'(note_done), 1);
        step();
        chk("dur0_done_end", 32'(note_done), 0);
        tick_pulse();
        chk("dur0_gen", 32'(generate_next), 0);

        // play=0 blocks requests
        do_load(20'h00300, 6'd4);
        play = 1'b0;
        tick_pulse();
        chk("noplay_gen", 32'(generate_next), 0);
        chk("noplay_overrun", 32'(overrun), 0);
        play = 1'b1;

        // Reset mid-request
        fetch(16'hC001);
        tick_pulse();
        chk("mid_gen", 32'(generate_next), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gen", 32'(generate_next), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_sample", 32'(out_sample), 0);
        chk("mid_rst_step", 32'(step_size), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_done", 32'(note_done), 0);

`ifdef SAMPLE_FETCHER_TIMEOUT_EN
        do_load(20'h00100, 6'd5);
        tick_pulse();
        step();
        repeat (14) step();
        chk("to_busy_last", 32'(busy), 1);
        chk("to_valid_last", 32'(out_valid), 0);
        step();
        chk("to_valid", 32'(out_valid), 1);
        chk("to_sample", 32'(out_sample), 0);
        chk("to_err", 32'(timeout_err), 1);
        chk("to_busy", 32'(busy), 0);
        sample_ready = 1'b1;
        sample       = 16'hDEAD;
        step();
        sample_ready = 1'b0;
        chk("late_ready_head", 32'(out_sample), 0);
        chk("late_ready_busy", 32'(busy), 0);
        tick_pulse();
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("to_rst_busy", 32'(busy), 0);
        chk("to_rst_valid", 32'(out_valid), 0);
        chk("to_rst_err", 32'(timeout_err), 0);
        step();
        rst_n = 1'b1;
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
